outport_credit_tx: RTL

- Per-output-port transmit stage directly downstream of the switch. Consumes one switch output port (out[i], data_ready_out[i]) and returns packet_sent[i] and credit_granted[i] to the switch.
- Holds flits in a small FIFO and drives them onto the physical link.
- Tracks per-VC credits for the downstream receiver's buffers, so the switch only forwards a flit when the far end has room for it.
- One instance per switch outport.

---
 rtl/outport_credit_tx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/outport_credit_tx.sv
// outport_credit_tx: transmit stage for one switch output port.
// Flits accepted from the switch are buffered in a small FIFO and sent on the
// link. Per-VC credit counters track free slots in the downstream receiver.
// A credit is taken when the flit is accepted, so every buffered flit already
// owns a downstream slot.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flit_in/flit_vc flit and VC from the switch, valid with data_ready_in
//   data_ready_in   switch offers a flit
//   packet_sent     flit accepted this cycle
//   credit_granted  per-VC "has credit" back to the switch (ACTIVE only)
//   link_up         link trained; drives DOWN/ACTIVE
//   credit_return   per-VC one-cycle pulse: downstream freed one slot
//   tx_flit/tx_vc   FIFO head onto the link (zero when not valid)
//   tx_valid        head valid; tx_ready completes the transfer
//   credit_err      sticky: credit returned while counter already full
module outport_credit_tx #(
   parameter  int NUM_VCS     = 2,
   parameter  int MAX_CREDITS = 4,
   parameter  int FIFO_DEPTH  = 2,
   parameter  int FLIT_W      = 32,
   localparam int VC_W        = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
   localparam int CNT_W       = $clog2(MAX_CREDITS + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [FLIT_W-1:0]  flit_in,
   input  logic [VC_W-1:0]    flit_vc,
   input  logic               data_ready_in,
   output logic               packet_sent,
   output logic [NUM_VCS-1:0] credit_granted,
   input  logic               link_up,
   input  logic [NUM_VCS-1:0] credit_return,
   output logic [FLIT_W-1:0]  tx_flit,
   output logic [VC_W-1:0]    tx_vc,
   output logic               tx_valid,
   input  logic               tx_ready,
   output logic               credit_err
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

   typedef struct packed {
      logic [FLIT_W-1:0] flit;
      logic [VC_W-1:0]   vc;
   } entry_t;

   typedef enum logic {DOWN, ACTIVE} state_t;

   state_t state, state_nx;
   logic   active, going_down;

   // link state FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= DOWN;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         DOWN:    if (link_up)  state_nx = ACTIVE;
         ACTIVE:  if (!link_up) state_nx = DOWN;
         default: state_nx = DOWN;
      endcase
   end

   assign active     = (state == ACTIVE);
   // leaving ACTIVE flushes the FIFO and reloads credits on the same edge
   assign going_down = active && !link_up;

   // FIFO
   entry_t             mem [FIFO_DEPTH];
   entry_t             head;
   logic [PTR_W-1:0]   rd_ptr, wr_ptr;
   logic [FCNT_W-1:0]  count;
   logic               full, empty, push, pop;

   assign full  = (count == FCNT_W'(FIFO_DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   assign tx_valid = active && !empty;
   assign pop      = tx_valid && tx_ready;
   assign tx_flit  = tx_valid ? head.flit : '0;
   assign tx_vc    = tx_valid ? head.vc   : '0;

   // credits
   logic [NUM_VCS-1:0][CNT_W-1:0] credit;
   logic [NUM_VCS-1:0]            inc, dec, sat;
   logic                          vc_has_credit, accept;

   // out-of-range VCs match no counter, so they are never accepted
   always_comb begin
      vc_has_credit = 1'b0;
      for (int v = 0; v < NUM_VCS; v++)
         if (flit_vc == VC_W'(v) && credit[v] != '0) vc_has_credit = 1'b1;
   end

   assign accept      = active && data_ready_in && vc_has_credit && (!full || pop);
   assign packet_sent = accept;
   assign push        = accept;

   always_comb begin
      inc = '0;
      dec = '0;
      sat = '0;
      for (int v = 0; v < NUM_VCS; v++) begin
         inc[v]            = active && credit_return[v];
         dec[v]            = accept && (flit_vc == VC_W'(v));
         sat[v]            = link_up && inc[v] && !dec[v] &&
                             (credit[v] == CNT_W'(MAX_CREDITS));
         credit_granted[v] = active && (credit[v] != '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int v = 0; v < NUM_VCS; v++) credit[v] <= CNT_W'(MAX_CREDITS);
      end else begin
         for (int v = 0; v < NUM_VCS; v++) begin
            if (going_down)
               credit[v] <= CNT_W'(MAX_CREDITS);
            else if (inc[v] && !dec[v] && credit[v] != CNT_W'(MAX_CREDITS))
               credit[v] <= credit[v] + 1'b1;
            else if (dec[v] && !inc[v])
               credit[v] <= credit[v] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       credit_err <= 1'b0;
      else if (|sat) credit_err <= 1'b1;
   end

   // FIFO pointers wrap naturally since depth is a power of 2
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (going_down) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // storage needs no reset: outputs are masked by tx_valid
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{flit: flit_in, vc: flit_vc};
   end
endmodule
